// File: rtl/jesd_tx_link_fsm.sv
// JESD204 transmit link-layer controller: CGS, ILA sequencing, sync-request handling and lane muxing.
// Define JESD_TX_ERR_REINIT_EN to re-initialise through ERR_K on short SYNC~ low runs in DATA.
module jesd_tx_link_fsm #(
  parameter int LANES           = 4,
  parameter int ILA_MF_W        = 8,
  parameter int SYNC_REQ_FRAMES = 5,
  parameter int ERR_K_FRAMES    = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                frame_clk,
  input  logic                lmfc_clk,
  input  logic                i_sync_n,
  input  logic                i_link_en,
  input  logic [LANES-1:0]    i_lane_en,
  input  logic [ILA_MF_W-1:0] i_ila_multiframe_length,
  output logic [2*LANES-1:0]  o_link_mux,
  output logic [ILA_MF_W:0]   o_ila_mf_idx,
  output logic                o_ila_start,
  output logic                o_link_up,
  output logic [2:0]          o_state
);

  localparam int CNT_W = ILA_MF_W + 1;
  localparam int EK_W  = (ERR_K_FRAMES > 1) ? $clog2(ERR_K_FRAMES) : 1;
  localparam logic [EK_W-1:0] EK_LAST  = EK_W'(ERR_K_FRAMES - 1);
  localparam logic [3:0]      SYNC_THR = 4'(SYNC_REQ_FRAMES);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_CGS       = 3'd1,
    ST_WAIT_LMFC = 3'd2,
    ST_ILA       = 3'd3,
    ST_DATA      = 3'd4,
    ST_ERR_K     = 3'd5
  } state_t;

  state_t               state_reg, state_next;
  logic                 run_reg;
  logic [3:0]           low_cnt_reg, low_cnt_next;
  logic [CNT_W-1:0]     ila_cnt_reg, ila_cnt_next;
  logic [CNT_W-1:0]     ila_len_reg, ila_len_next;
  logic [EK_W-1:0]      erk_cnt_reg, erk_cnt_next;
  logic                 sync_req;
  logic                 err_rise;
  logic [1:0]           sel_next;
  logic [2*LANES-1:0]   mux_next;
  logic [2*LANES-1:0]   mux_reg;
  logic [CNT_W-1:0]     idx_reg;
  logic                 start_reg;
  logic                 link_up_reg;

`ifdef JESD_TX_ERR_REINIT_EN
  logic sync_prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sync_prev_reg <= 1'b1;
    else if (run_reg)
      sync_prev_reg <= i_sync_n;
  end

  // A rise of SYNC~ that ends a run shorter than the request threshold is a link error.
  assign err_rise = !sync_prev_reg && i_sync_n && (low_cnt_reg < SYNC_THR);
`else
  assign err_rise = 1'b0;
`endif

  always_comb begin
    low_cnt_next = low_cnt_reg;
    if (i_sync_n)
      low_cnt_next = '0;
    else if (frame_clk && (low_cnt_reg != 4'd15))
      low_cnt_next = low_cnt_reg + 4'd1;
    sync_req = (low_cnt_next >= SYNC_THR);

    state_next   = state_reg;
    ila_cnt_next = ila_cnt_reg;
    ila_len_next = ila_len_reg;
    erk_cnt_next = erk_cnt_reg;

    case (state_reg)
      ST_IDLE:      if (i_link_en) state_next = ST_CGS;
      ST_CGS:       if (i_sync_n) state_next = ST_WAIT_LMFC;
      ST_WAIT_LMFC: if (lmfc_clk) state_next = ST_ILA;
      ST_ILA: begin
        if (lmfc_clk) begin
          // Compare at full counter width so an all-ones length never wraps.
          if ((ila_cnt_reg + CNT_W'(1)) == (ila_len_reg + CNT_W'(1)))
            state_next = ST_DATA;
          else
            ila_cnt_next = ila_cnt_reg + CNT_W'(1);
        end
      end
      ST_DATA:      if (err_rise) state_next = ST_ERR_K;
      ST_ERR_K: begin
        if (frame_clk) begin
          if (erk_cnt_reg == EK_LAST)
            state_next = ST_WAIT_LMFC;
          else
            erk_cnt_next = erk_cnt_reg + EK_W'(1);
        end
      end
      default:      state_next = ST_IDLE;
    endcase

    if (sync_req && (state_reg != ST_IDLE) && (state_reg != ST_CGS))
      state_next = ST_CGS;
    if (!i_link_en)
      state_next = ST_IDLE;

    if ((state_next == ST_ILA) && (state_reg != ST_ILA)) begin
      ila_cnt_next = '0;
      ila_len_next = {1'b0, i_ila_multiframe_length};
    end
    if ((state_next == ST_ERR_K) && (state_reg != ST_ERR_K))
      erk_cnt_next = '0;
  end

  always_comb begin
    sel_next = 2'd3;
    case (state_next)
      ST_ILA:                         sel_next = 2'd2;
      ST_DATA:                        sel_next = 2'd0;
      ST_CGS, ST_WAIT_LMFC, ST_ERR_K: sel_next = 2'd1;
      default:                        sel_next = 2'd3;
    endcase
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign mux_next[2*gi +: 2] = i_lane_en[gi] ? sel_next : 2'd3;
  end

  // run_reg holds everything for the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_reg     <= 1'b0;
      state_reg   <= ST_IDLE;
      low_cnt_reg <= '0;
      ila_cnt_reg <= '0;
      ila_len_reg <= '0;
      erk_cnt_reg <= '0;
      mux_reg     <= '1;
      idx_reg     <= '0;
      start_reg   <= 1'b0;
      link_up_reg <= 1'b0;
    end else if (!run_reg) begin
      run_reg <= 1'b1;
    end else begin
      state_reg   <= state_next;
      low_cnt_reg <= low_cnt_next;
      ila_cnt_reg <= ila_cnt_next;
      ila_len_reg <= ila_len_next;
      erk_cnt_reg <= erk_cnt_next;
      mux_reg     <= mux_next;
      idx_reg     <= (state_next == ST_ILA) ? ila_cnt_next : '0;
      start_reg   <= (state_next == ST_ILA) && (state_reg != ST_ILA);
      link_up_reg <= (state_next == ST_DATA);
    end
  end

  assign o_link_mux   = mux_reg;
  assign o_ila_mf_idx = idx_reg;
  assign o_ila_start  = start_reg;
  assign o_link_up    = link_up_reg;
  assign o_state      = state_reg;

endmodule

// File: tb/tb_jesd_tx_link_fsm.sv
// Self-checking bench for jesd_tx_link_fsm: randomized strobe periods and ILA lengths,
// expectations derived from frame/multiframe arithmetic rather than a state-machine copy.
module tb_jesd_tx_link_fsm;

  localparam int LANES = 4;
  localparam int MFW   = 8;
  localparam int SRF   = 5;
  localparam int EKF   = 4;

  localparam logic [2:0] S_IDLE = 3'd0, S_CGS = 3'd1, S_WAIT = 3'd2,
                         S_ILA = 3'd3, S_DATA = 3'd4, S_ERRK = 3'd5;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             frame_clk = 1'b0;
  logic             lmfc_clk = 1'b0;
  logic             sync_n = 1'b1;
  logic             link_en = 1'b0;
  logic [LANES-1:0] lane_en = '1;
  logic [MFW-1:0]   ila_len = '0;
  logic [2*LANES-1:0] link_mux;
  logic [MFW:0]     ila_idx;
  logic             ila_start;
  logic             link_up;
  logic [2:0]       state;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int fper;
  int lper;

  always #5 clk = ~clk;

  jesd_tx_link_fsm #(
    .LANES(LANES), .ILA_MF_W(MFW), .SYNC_REQ_FRAMES(SRF), .ERR_K_FRAMES(EKF)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .frame_clk(frame_clk),
    .lmfc_clk(lmfc_clk),
    .i_sync_n(sync_n),
    .i_link_en(link_en),
    .i_lane_en(lane_en),
    .i_ila_multiframe_length(ila_len),
    .o_link_mux(link_mux),
    .o_ila_mf_idx(ila_idx),
    .o_ila_start(ila_start),
    .o_link_up(link_up),
    .o_state(state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:0] sel_of(input logic [2:0] st);
    case (st)
      S_ILA:                 return 2'd2;
      S_DATA:                return 2'd0;
      S_CGS, S_WAIT, S_ERRK: return 2'd1;
      default:               return 2'd3;
    endcase
  endfunction

  function automatic logic [2*LANES-1:0] exp_mux(input logic [1:0] sel);
    logic [2*LANES-1:0] m;
    for (int i = 0; i < LANES; i++) m[2*i +: 2] = lane_en[i] ? sel : 2'd3;
    return m;
  endfunction

  task automatic observe(input string tag, input logic [2:0] st, input int idx);
    chk({tag, "/state"}, state, st);
    chk({tag, "/mux"}, link_mux, exp_mux(sel_of(st)));
    chk({tag, "/link_up"}, link_up, st == S_DATA);
    chk({tag, "/idx"}, ila_idx, idx);
  endtask

  // Strobes come from a free-running cycle count; every LMFC edge is also a frame edge.
  task automatic step();
    frame_clk = (cyc % fper) == 0;
    lmfc_clk  = (cyc % lper) == 0;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic wait_ila(input int len);
    int g = 0;
    ila_len = MFW'(len);
    do begin
      step();
      g++;
      if (!lmfc_clk) chk("wait_lmfc_hold", state, S_WAIT);
    end while (!lmfc_clk && g < 64);
    observe("ila_entry", S_ILA, 0);
    chk("ila_start_pulse", ila_start, 1);
  endtask

  task automatic run_ila(input int len);
    int total;
    logic [2:0] st;
    wait_ila(len);
    ila_len = MFW'($urandom);
    total = (len + 1) * lper;
    for (int t = 1; t <= total; t++) begin
      step();
      st = (t < total) ? S_ILA : S_DATA;
      observe("ila_run", st, (st == S_ILA) ? t / lper : 0);
      if (t == 1) chk("ila_start_once", ila_start, 0);
    end
  endtask

  task automatic bring_up(input int len);
    int n = 0;
    link_en = 1'b0; sync_n = 1'b1;
    step();
    observe("bu_idle", S_IDLE, 0);
    link_en = 1'b1; sync_n = 1'b0;
    step();
    observe("bu_cgs", S_CGS, 0);
    while (n < 20) begin
      step();
      if (frame_clk) n++;
      chk("bu_cgs_hold", state, S_CGS);
    end
    while ((cyc % lper) != 0) step();
    sync_n = 1'b1;
    step();  // this edge also carries an LMFC strobe, which must not start ILA
    observe("bu_wait_entry", S_WAIT, 0);
    run_ila(len);
  endtask

  task automatic sync_request(input logic [2:0] cur);
    int n = 0;
    sync_n = 1'b0;
    while (n < SRF) begin
      step();
      if (frame_clk) n++;
      chk("sync_req_state", state, (n >= SRF) ? S_CGS : cur);
    end
    chk("sync_req_mux", link_mux, exp_mux(2'd1));
  endtask

  task automatic resume();
    sync_n = 1'b1;
    step();
    observe("resume_wait", S_WAIT, 0);
  endtask

  task automatic short_run(input int nf);
    int n = 0;
    sync_n = 1'b0;
    while (n < nf) begin
      step();
      if (frame_clk) n++;
      chk("short_run_hold", state, S_DATA);
    end
    sync_n = 1'b1;
    step();
`ifdef JESD_TX_ERR_REINIT_EN
    observe("errk_entry", S_ERRK, 0);
    n = 0;
    while (n < EKF) begin
      step();
      if (frame_clk) n++;
      chk("errk_frames", state, (n >= EKF) ? S_WAIT : S_ERRK);
    end
    run_ila($urandom_range(0, 3));
`else
    repeat (3) begin
      step();
      observe("short_run_ignored", S_DATA, 0);
    end
`endif
  endtask

  initial begin
    fper = $urandom_range(1, 3);
    lper = fper * $urandom_range(2, 4);

    step();
    step();
    observe("reset", S_IDLE, 0);
    chk("reset_start", ila_start, 0);

    rst_n = 1'b1; link_en = 1'b1; sync_n = 1'b0;
    step();
    chk("rst_release_hold", state, S_IDLE);
    step();
    observe("rst_release_cgs", S_CGS, 0);

    bring_up(3);
    lane_en = 4'b0101;
    step();
    chk("lane_mask", link_mux, 8'hCC);
    lane_en = 4'b1111;
    step();
    chk("lane_unmask", link_mux, 8'h00);

    short_run(4);
    short_run(2);
    short_run($urandom_range(1, 4));

    sync_request(S_DATA);
    resume();
    run_ila($urandom_range(0, 4));

    bring_up($urandom_range(0, 6));
    bring_up(255);

    sync_request(S_DATA);
    resume();
    wait_ila(20);
    repeat (2) step();
    link_en = 1'b0;
    step();
    observe("abort_link_en", S_IDLE, 0);

    bring_up(1);
    sync_request(S_DATA);
    resume();
    wait_ila(20);
    sync_request(S_ILA);
    resume();
    run_ila(1);

    sync_request(S_DATA);
    resume();
    wait_ila(20);
    rst_n = 1'b0;
    #1;
    observe("async_reset", S_IDLE, 0);
    chk("async_reset_start", ila_start, 0);
    step();
    chk("reset_held", state, S_IDLE);
    rst_n = 1'b1; link_en = 1'b1; sync_n = 1'b0;
    step();
    chk("rerelease_hold", state, S_IDLE);
    step();
    observe("rerelease_cgs", S_CGS, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
